// File: rtl/fpro_arb_pkg.sv
// Shared types and widths for the two-master FPro bus arbiter.
package fpro_arb_pkg;

    localparam int FP_ADDR_W = 21;
    localparam int FP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 wr;
        logic                 video;
        logic [FP_ADDR_W-1:0] addr;
        logic [FP_DATA_W-1:0] wr_data;
    } fp_req_t;

endpackage

// File: rtl/fpro_bus_arbiter_if.sv
// Bundle of both master req/ack ports plus the shared FPro bus.
interface fpro_bus_arbiter_if;
    import fpro_arb_pkg::*;

    logic                 m0_req, m1_req;
    logic                 m0_wr, m1_wr;
    logic                 m0_video, m1_video;
    logic [FP_ADDR_W-1:0] m0_addr, m1_addr;
    logic [FP_DATA_W-1:0] m0_wr_data, m1_wr_data;
    logic                 m0_lock, m1_lock;
    logic                 m0_ack, m1_ack;
    logic [FP_DATA_W-1:0] m0_rd_data, m1_rd_data;

    logic                 fp_video_cs, fp_mmio_cs, fp_wr, fp_rd;
    logic [FP_ADDR_W-1:0] fp_addr;
    logic [FP_DATA_W-1:0] fp_wr_data;
    logic [FP_DATA_W-1:0] fp_rd_data;

    modport slave (
        input  m0_req, m0_wr, m0_video, m0_addr, m0_wr_data, m0_lock,
        input  m1_req, m1_wr, m1_video, m1_addr, m1_wr_data, m1_lock,
        output m0_ack, m0_rd_data, m1_ack, m1_rd_data,
        output fp_video_cs, fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
        input  fp_rd_data
    );

    modport master (
        output m0_req, m0_wr, m0_video, m0_addr, m0_wr_data, m0_lock,
        output m1_req, m1_wr, m1_video, m1_addr, m1_wr_data, m1_lock,
        input  m0_ack, m0_rd_data, m1_ack, m1_rd_data,
        input  fp_video_cs, fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
        output fp_rd_data
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the master not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Round-robin arbiter sharing one FPro bus between two req/ack masters.
// Optional grant locking for back-to-back transactions: FPRO_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | arbitrate; latch granted master's fields into holding regs
// ISSUE | single-cycle fp_wr/fp_rd strobe from holding regs
// WAIT  | count down read latency, sample fp_rd_data at cnt == 0
// DONE  | one-cycle ack to granted master, record it as last served
module fpro_bus_arbiter
    import fpro_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    fpro_bus_arbiter_if.slave  bus
);

    localparam logic [1:0] CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t               state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 last_q, last_d;
    logic [1:0]           cnt_q, cnt_d;
    fp_req_t              hold_q, hold_d;
    logic [FP_DATA_W-1:0] rd_q, rd_d;

    logic                 pick_gnt, pick_valid;
    fp_req_t              m_fields [2];

    always_comb begin
        m_fields[0] = '{wr: bus.m0_wr, video: bus.m0_video,
                        addr: bus.m0_addr, wr_data: bus.m0_wr_data};
        m_fields[1] = '{wr: bus.m1_wr, video: bus.m1_video,
                        addr: bus.m1_addr, wr_data: bus.m1_wr_data};
    end

`ifdef FPRO_ARB_LOCK_EN
    logic [1:0] m_req, m_lock;
    assign m_req  = {bus.m1_req, bus.m0_req};
    assign m_lock = {bus.m1_lock, bus.m0_lock};
`endif

    rr_pick2 u_pick (
        .req   ({bus.m1_req, bus.m0_req}),
        .last  (last_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    hold_d  = m_fields[pick_gnt];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (hold_q.wr) begin
                    state_d = DONE;
                end else if (RD_LAT == 0) begin
                    rd_d    = bus.fp_rd_data;
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rd_d    = bus.fp_rd_data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
`ifdef FPRO_ARB_LOCK_EN
                // Locked master skips IDLE, so the other master cannot win arbitration.
                if (m_lock[gnt_q] && m_req[gnt_q]) begin
                    hold_d  = m_fields[gnt_q];
                    state_d = ISSUE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 2'd0;
            hold_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rd_q    <= rd_d;
        end
    end

    logic issue, done;
    assign issue = (state_q == ISSUE);
    assign done  = (state_q == DONE);

    assign bus.fp_wr       = issue &  hold_q.wr;
    assign bus.fp_rd       = issue & ~hold_q.wr;
    assign bus.fp_video_cs = issue &  hold_q.video;
    assign bus.fp_mmio_cs  = issue & ~hold_q.video;
    assign bus.fp_addr     = hold_q.addr;
    assign bus.fp_wr_data  = hold_q.wr_data;

    assign bus.m0_ack     = done & ~gnt_q;
    assign bus.m1_ack     = done &  gnt_q;
    assign bus.m0_rd_data = rd_q;
    assign bus.m1_rd_data = rd_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Scoreboard bench for fpro_bus_arbiter (RD_LAT = 2 main instance, RD_LAT = 0 side instance).
module tb_fpro_bus_arbiter;

    localparam int RD_LAT = 2;

    typedef struct {
        logic        wr;
        logic        video;
        logic [20:0] addr;
        logic [31:0] data;
        logic        lock;
    } xact_t;

    typedef struct {
        int          m;
        logic        wr;
        logic        video;
        logic [20:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fpro_bus_arbiter_if bus ();
    fpro_bus_arbiter_if bus0 ();

    fpro_bus_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    fpro_bus_arbiter #(.RD_LAT(0)) dut_lat0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read responder: valid data only in the cycle RD_LAT after the strobe, junk otherwise.
    int          sample_at = -100;
    logic [31:0] rd_resp = 32'h0;
    always @(negedge clk) begin
        if (bus.fp_rd) sample_at = cyc + RD_LAT;
        bus.fp_rd_data = (cyc == sample_at) ? rd_resp : (32'hBAD0_0000 | 32'(cyc));
    end
    assign bus0.fp_rd_data = bus0.fp_rd ? 32'hCAFE_F00D : 32'h0BAD_0BAD;

    exp_t  strobe_q[$];
    exp_t  ack_q[$];
    int    strobe_cyc_q[$];
    int    last_strobe = 0;
    xact_t mq0[$];
    xact_t mq1[$];

    task automatic expect_x(input int m, input logic wr, input logic video, input logic [20:0] addr,
                            input logic [31:0] data, input logic [31:0] rd, input bit with_ack);
        exp_t e;
        e = '{m: m, wr: wr, video: video, addr: addr, data: data, rd: rd};
        strobe_q.push_back(e);
        if (with_ack) ack_q.push_back(e);
    endtask

    task automatic add_x(input int m, input logic wr, input logic video, input logic [20:0] addr,
                         input logic [31:0] data, input logic lock);
        xact_t x;
        x = '{wr: wr, video: video, addr: addr, data: data, lock: lock};
        if (m == 0) mq0.push_back(x);
        else        mq1.push_back(x);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes the bus or acks a master.
    exp_t e_mon;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.fp_wr || bus.fp_rd) begin
                chk("strobe_exclusive", 32'(bus.fp_wr & bus.fp_rd), 32'd0);
                if (strobe_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_strobe: got strobe addr 0x%06h required none", bus.fp_addr);
                end else begin
                    e_mon = strobe_q.pop_front();
                    chk("strobe_wr", 32'(bus.fp_wr), 32'(e_mon.wr));
                    chk("strobe_cs", {30'd0, bus.fp_video_cs, bus.fp_mmio_cs},
                        {30'd0, e_mon.video, ~e_mon.video});
                    chk("strobe_addr", 32'(bus.fp_addr), 32'(e_mon.addr));
                    if (e_mon.wr) chk("strobe_wr_data", bus.fp_wr_data, e_mon.data);
                end
                last_strobe = cyc;
                strobe_cyc_q.push_back(cyc);
            end else if (bus.fp_video_cs || bus.fp_mmio_cs) begin
                n_cmp++; n_bad++;
                $display("FAIL cs_without_strobe: got video_cs=%0b mmio_cs=%0b required 0",
                         bus.fp_video_cs, bus.fp_mmio_cs);
            end
            if (bus.m0_ack || bus.m1_ack) begin
                if (ack_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b required none",
                             bus.m0_ack, bus.m1_ack);
                end else begin
                    e_mon = ack_q.pop_front();
                    chk("ack_master", {30'd0, bus.m1_ack, bus.m0_ack}, (e_mon.m == 0) ? 32'd1 : 32'd2);
                    chk("ack_latency", 32'(cyc - last_strobe), e_mon.wr ? 32'd1 : 32'(1 + RD_LAT));
                    if (!e_mon.wr)
                        chk("rd_data", (e_mon.m == 0) ? bus.m0_rd_data : bus.m1_rd_data, e_mon.rd);
                end
            end
        end
    end

    task automatic drive(input int m, input logic req, input xact_t x);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_wr = x.wr; bus.m0_video = x.video;
            bus.m0_addr = x.addr; bus.m0_wr_data = x.data; bus.m0_lock = x.lock;
        end else begin
            bus.m1_req = req; bus.m1_wr = x.wr; bus.m1_video = x.video;
            bus.m1_addr = x.addr; bus.m1_wr_data = x.data; bus.m1_lock = x.lock;
        end
    endtask

    task automatic sync_cyc();
        @(posedge clk);
        #1;
    endtask

    // Master driver: keeps req high across its queue, presenting the next fields during the ack cycle.
    task automatic run_master(input int m, output int req_cyc, output int ack_cyc);
        xact_t x, idle_x;
        bit    got;
        idle_x  = '{wr: 1'b0, video: 1'b0, addr: 21'd0, data: 32'd0, lock: 1'b0};
        req_cyc = cyc;
        ack_cyc = -1;
        while (((m == 0) ? mq0.size() : mq1.size()) > 0) begin
            x = (m == 0) ? mq0[0] : mq1[0];
            drive(m, 1'b1, x);
            got = 1'b0;
            for (int k = 0; k < 60 && !got; k++) begin
                sync_cyc();
                got = (m == 0) ? bus.m0_ack : bus.m1_ack;
            end
            if (!got) begin
                n_cmp++; n_bad++;
                $display("FAIL ack_timeout_m%0d: got no ack required ack within 60 cycles", m);
                if (m == 0) mq0.delete(); else mq1.delete();
            end else begin
                if (m == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                ack_cyc = cyc;
            end
        end
        drive(m, 1'b0, idle_x);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish before 400000");
        $fatal(1, "watchdog");
    end

    initial begin
        int    r0, a0, r1, a1, base, k;
        bit    got;
        xact_t idle_x, xr;
        idle_x = '{wr: 1'b0, video: 1'b0, addr: 21'd0, data: 32'd0, lock: 1'b0};
        drive(0, 1'b0, idle_x);
        drive(1, 1'b0, idle_x);
        bus0.m0_req = 1'b0; bus0.m0_wr = 1'b0; bus0.m0_video = 1'b0; bus0.m0_addr = '0;
        bus0.m0_wr_data = '0; bus0.m0_lock = 1'b0;
        bus0.m1_req = 1'b0; bus0.m1_wr = 1'b0; bus0.m1_video = 1'b0; bus0.m1_addr = '0;
        bus0.m1_wr_data = '0; bus0.m1_lock = 1'b0;

        reset_n = 1'b0;
        repeat (3) sync_cyc();
        chk("rst_fp_ctrl", {28'd0, bus.fp_video_cs, bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd}, 32'd0);
        chk("rst_fp_addr", 32'(bus.fp_addr), 32'd0);
        chk("rst_fp_wr_data", bus.fp_wr_data, 32'd0);
        chk("rst_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        chk("rst_rd_data", bus.m0_rd_data | bus.m1_rd_data, 32'd0);
        reset_n = 1'b1;
        repeat (2) sync_cyc();

        // Master 0 lone MMIO write.
        add_x(0, 1'b1, 1'b0, 21'h00010, 32'hDEADBEEF, 1'b0);
        expect_x(0, 1'b1, 1'b0, 21'h00010, 32'hDEADBEEF, 32'h0, 1'b1);
        run_master(0, r0, a0);
        chk("m0_write_ack_lat", 32'(a0 - r0), 32'd2);
        repeat (2) sync_cyc();

        // Master 1 lone video read at the top of the address space.
        rd_resp = 32'h12345678;
        add_x(1, 1'b0, 1'b1, 21'h1FFFFF, 32'h0, 1'b0);
        expect_x(1, 1'b0, 1'b1, 21'h1FFFFF, 32'h0, 32'h12345678, 1'b1);
        run_master(1, r1, a1);
        chk("m1_read_ack_lat", 32'(a1 - r1), 32'd4);
        chk("m1_rd_data_hold", bus.m1_rd_data, 32'h12345678);
        repeat (2) sync_cyc();

        // Continuous contention: strict alternation 0,1,0,1.
        rd_resp = 32'h5A5AA5A5;
        add_x(0, 1'b1, 1'b0, 21'h00100, 32'h11111111, 1'b0);
        add_x(0, 1'b1, 1'b1, 21'h00101, 32'h22222222, 1'b0);
        add_x(1, 1'b0, 1'b1, 21'h00200, 32'h0, 1'b0);
        add_x(1, 1'b0, 1'b0, 21'h00201, 32'h0, 1'b0);
        expect_x(0, 1'b1, 1'b0, 21'h00100, 32'h11111111, 32'h0, 1'b1);
        expect_x(1, 1'b0, 1'b1, 21'h00200, 32'h0, 32'h5A5AA5A5, 1'b1);
        expect_x(0, 1'b1, 1'b1, 21'h00101, 32'h22222222, 32'h0, 1'b1);
        expect_x(1, 1'b0, 1'b0, 21'h00201, 32'h0, 32'h5A5AA5A5, 1'b1);
        fork
            run_master(0, r0, a0);
            run_master(1, r1, a1);
        join
        repeat (2) sync_cyc();

        // Reset during WAIT aborts the read: no ack, outputs cleared.
        xr = '{wr: 1'b0, video: 1'b1, addr: 21'h00300, data: 32'h0, lock: 1'b0};
        expect_x(1, 1'b0, 1'b1, 21'h00300, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b1, xr);
        got = 1'b0;
        for (k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.fp_rd;
        end
        chk("abort_read_strobe_seen", 32'(got), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        drive(1, 1'b0, idle_x);
        @(negedge clk);
        chk("abort_fp_ctrl", {28'd0, bus.fp_video_cs, bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd}, 32'd0);
        chk("abort_acks", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        chk("abort_rd_data", bus.m1_rd_data, 32'd0);
        sync_cyc();
        reset_n = 1'b1;
        repeat (4) sync_cyc();

        // Fresh contention after reset: master 0 must win.
        add_x(0, 1'b1, 1'b0, 21'h00400, 32'h44444444, 1'b0);
        add_x(1, 1'b1, 1'b1, 21'h00401, 32'h55555555, 1'b0);
        expect_x(0, 1'b1, 1'b0, 21'h00400, 32'h44444444, 32'h0, 1'b1);
        expect_x(1, 1'b1, 1'b1, 21'h00401, 32'h55555555, 32'h0, 1'b1);
        fork
            run_master(0, r0, a0);
            run_master(1, r1, a1);
        join
        chk("post_abort_m0_first", 32'(a0 < a1), 32'd1);
        repeat (2) sync_cyc();

        // Locked burst from master 0 while master 1 also requests.
        for (int i = 0; i < 4; i++) add_x(0, 1'b1, 1'b0, 21'h00500 + 21'(i), 32'h50000000 + 32'(i), 1'b1);
        add_x(1, 1'b1, 1'b0, 21'h00600, 32'h60000000, 1'b0);
        add_x(1, 1'b1, 1'b0, 21'h00601, 32'h60000001, 1'b0);
`ifdef FPRO_ARB_LOCK_EN
        for (int i = 0; i < 4; i++) expect_x(0, 1'b1, 1'b0, 21'h00500 + 21'(i), 32'h50000000 + 32'(i), 32'h0, 1'b1);
        expect_x(1, 1'b1, 1'b0, 21'h00600, 32'h60000000, 32'h0, 1'b1);
        expect_x(1, 1'b1, 1'b0, 21'h00601, 32'h60000001, 32'h0, 1'b1);
`else
        expect_x(0, 1'b1, 1'b0, 21'h00500, 32'h50000000, 32'h0, 1'b1);
        expect_x(1, 1'b1, 1'b0, 21'h00600, 32'h60000000, 32'h0, 1'b1);
        expect_x(0, 1'b1, 1'b0, 21'h00501, 32'h50000001, 32'h0, 1'b1);
        expect_x(1, 1'b1, 1'b0, 21'h00601, 32'h60000001, 32'h0, 1'b1);
        expect_x(0, 1'b1, 1'b0, 21'h00502, 32'h50000002, 32'h0, 1'b1);
        expect_x(0, 1'b1, 1'b0, 21'h00503, 32'h50000003, 32'h0, 1'b1);
`endif
        base = strobe_cyc_q.size();
        fork
            run_master(0, r0, a0);
            run_master(1, r1, a1);
        join
        chk("lock_test_strobe_count", 32'(strobe_cyc_q.size() - base), 32'd6);
`ifdef FPRO_ARB_LOCK_EN
        for (int i = 1; i < 4; i++)
            if (strobe_cyc_q.size() >= base + 4)
                chk("lock_strobe_spacing", 32'(strobe_cyc_q[base + i] - strobe_cyc_q[base + i - 1]), 32'd2);
`endif
        repeat (2) sync_cyc();

        // RD_LAT = 0 instance: data sampled in the strobe cycle, ack at +2.
        bus0.m0_req = 1'b1; bus0.m0_wr = 1'b0; bus0.m0_video = 1'b0; bus0.m0_addr = 21'h00777;
        r0 = cyc;
        got = 1'b0;
        for (k = 0; k < 20 && !got; k++) begin
            sync_cyc();
            got = bus0.m0_ack;
        end
        bus0.m0_req = 1'b0;
        chk("lat0_ack_seen", 32'(got), 32'd1);
        chk("lat0_ack_lat", 32'(cyc - r0), 32'd2);
        chk("lat0_m0_rd_data", bus0.m0_rd_data, 32'hCAFEF00D);
        chk("lat0_m1_rd_data_shared", bus0.m1_rd_data, 32'hCAFEF00D);
        repeat (3) sync_cyc();

        for (k = 0; k < 20 && (strobe_q.size() != 0 || ack_q.size() != 0); k++) sync_cyc();
        chk("sb_strobe_drained", 32'(strobe_q.size()), 32'd0);
        chk("sb_ack_drained", 32'(ack_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpro_bus_arbiter.md
# fpro_bus_arbiter

Two-master arbiter sharing one FPro bus (video and MMIO spaces) between the MicroBlaze MCS bridge and a second master such as a DMA engine or debug port. Each master presents one transaction at a time with a req/ack handshake. The arbiter grants the bus round-robin and drives exactly one single-cycle FPro read or write strobe per transaction. For reads, it captures `fp_rd_data` after a fixed latency and returns it with the ack.

## Interface
- `RD_LAT`, default 1: cycles from the `fp_rd` strobe cycle to the `fp_rd_data` sample cycle; legal range 0..3.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `mI_req`  in  1  master I (I = 0, 1) transaction request; held until `mI_ack`.
- `mI_wr`  in  1  1 = write, 0 = read; stable while `mI_req && !mI_ack`.
- `mI_video`  in  1  1 = video space, 0 = MMIO space.
- `mI_addr`  in  21  word address.
- `mI_wr_data`  in  32  write data.
- `mI_lock`  in  1  keep grant for next transaction (see Configuration).
- `mI_ack`  out  1  one-cycle completion pulse.
- `mI_rd_data`  out  32  read data; valid when `mI_ack` is high after a read; holds last value otherwise.
- `fp_video_cs`, `fp_mmio_cs`, `fp_wr`, `fp_rd`  out  1 each  FPro bus controls.
- `fp_addr`  out  21  FPro word address.
- `fp_wr_data`  out  32  FPro write data.
- `fp_rd_data`  in  32  FPro read data.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE. A registered `gnt` (0/1) and `last` (last master served) select the active master.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If exactly one `mI_req` is high, grant that master.
  - If both are high, grant `!last`.
  - On a grant, latch wr, video, addr and wr_data from the granted master into holding registers and go to ISSUE.
- **ISSUE (one cycle):**
  - Drive the FPro bus from the holding registers. `fp_video_cs = video`, `fp_mmio_cs = !video`, and `fp_wr` or `fp_rd` is high.
  - Write: go to DONE.
  - Read with `RD_LAT = 0`: sample `fp_rd_data` in this cycle and go to DONE.
  - Read with `RD_LAT > 0`: load `cnt = RD_LAT - 1` and go to WAIT.
- **WAIT:**
  - All FPro controls are 0; address and data may hold their values.
  - When `cnt == 0`, sample `fp_rd_data` into the read-data register and go to DONE; otherwise decrement `cnt`.
- **DONE:**
  - `mI_ack = 1` for the granted master only, and `last <= gnt`.
  - Next state is IDLE, except for the lock case in Configuration.
- FPro strobes are high only in ISSUE: exactly one `fp_wr` or `fp_rd` cycle per transaction.
- A master dropping `mI_req` mid-transaction is a protocol violation. The arbiter completes the transaction and still pulses ack.
- A request arriving during a transaction waits. Arbitration only happens in IDLE.
- `mI_rd_data` is a single shared register fanned out to both masters and is updated only on read completion.

## Timing
- Reset values:
  - state = IDLE, `last = 1` (master 0 wins the first contention), `gnt = 0`, `cnt = 0`, holding registers 0, read-data register 0.
  - All outputs 0, including all `fp_*`, both acks and both `rd_data`.
- Reset asserted mid-transaction aborts on the next edge: no further strobe and no ack.
- FPro outputs and acks are decoded from registered state only. There is no combinational path from `mI_*` inputs to any output.
- Latency from the req-sampled edge (IDLE):
  - Write: strobe at cycle +1, ack at +2.
  - Read: strobe at +1, ack at +2+`RD_LAT`.
- Throughput without lock: one transaction per 3 cycles (writes) or 3+`RD_LAT` cycles (reads).

## Configuration
- `FPRO_ARB_LOCK_EN`:
  - **Defined:** in DONE, if `mI_lock` and `mI_req` of the granted master are both high, go directly to ISSUE with the same grant and latch the new fields in that DONE cycle. `last` is still updated. This gives back-to-back writes every 2 cycles, and the other master waits until the lock drops.
  - **Undefined:** `mI_lock` ports exist but are ignored, and DONE always returns to IDLE.

## Structure
- Package `fpro_arb_pkg`:
  - `state_t` enum (IDLE, ISSUE, WAIT, DONE).
  - `FP_ADDR_W = 21`, `FP_DATA_W = 32`.
  - Typedef `fp_req_t` (wr, video, addr, wr_data) used for the holding registers.
- Sub-module `rr_pick2`: combinational two-way round-robin picker (req[1:0], last → gnt, valid).

## Test plan
- Master 0 alone writes addr `0x00010`, data `0xDEADBEEF`, MMIO → `fp_mmio_cs = 1` and `fp_wr = 1` for exactly one cycle with those values; `m0_ack` 2 cycles after req is sampled.
- Master 1 reads video addr `0x1FFFFF` with `RD_LAT = 2` and `fp_rd_data = 0x12345678` presented in the sample cycle → `m1_ack` at +4, `m1_rd_data = 0x12345678`, `fp_video_cs` high only in the strobe cycle.
- Both masters request continuously after reset → grants alternate 0,1,0,1; no strobe cycle ever has `fp_wr` and `fp_rd` both high.
- `reset_n` low during WAIT → all outputs 0 next cycle; no ack; a fresh request afterwards completes normally, with master 0 winning contention.
- With `FPRO_ARB_LOCK_EN`, master 0 issues 4 locked writes while master 1 also requests → 4 master-0 strobes 2 cycles apart, then master 1 is granted; without the macro, strobes interleave 0,1,0,1.
- `RD_LAT = 0` read → data sampled in the strobe cycle; ack at +2.
